j_slatch_bank: RTL and testbench

//  Parametrised bank of CHANNELS settable, enable-gated latches, each WIDTH bits.

---
 rtl/j_latch_pkg.sv | 19 +
 rtl/j_slatch_bank_if.sv | 26 ++
 rtl/j_slatch_chan.sv | 39 +++
 rtl/j_slatch_bank.sv | 74 +++++++
 tb/tb_j_slatch_bank.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/j_latch_pkg.sv
// Shared types and helpers for the Jerry settable-latch bank.
// Channel widths up to MAX_WIDTH bits are supported by ALL_ONES.
package j_latch_pkg;

  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_SET,
    OP_LOAD,
    OP_SHIFT
  } latch_op_t;

  function automatic int chan_slice(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/j_slatch_bank_if.sv
// Bus bundle of the latch bank: emulated latch clock, load/set/shift controls, contents.
interface j_slatch_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);

  logic                      cp;
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS*WIDTH-1:0] d;
  logic [CHANNELS-1:0]       setl;
  logic                      shift;
  logic [WIDTH-1:0]          si;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS-1:0]       chg;

  modport master (
    output cp, en, d, setl, shift, si,
    input  q, chg
  );

  modport slave (
    input  cp, en, d, setl, shift, si,
    output q, chg
  );

endinterface

// File: rtl/j_slatch_chan.sv
// One WIDTH-bit settable latch channel; the op comes pre-decoded from the bank.
// chg is registered and marks the cycle after q took a different value.
module j_slatch_chan
  import j_latch_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  latch_op_t        op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             chg
);

  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    q_nxt = q;
    unique case (op)
      OP_SET:            q_nxt = ALL_ONES[WIDTH-1:0];
      OP_LOAD, OP_SHIFT: q_nxt = load_val;
      default:           q_nxt = q;
    endcase
  end

  // latch state and change flag
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      q   <= RESET_VAL;
      chg <= 1'b0;
    end else begin
      q   <= q_nxt;
      chg <= (q_nxt != q);
    end
  end

endmodule

// File: rtl/j_slatch_bank.sv
// Bank of CHANNELS settable latches loaded on sampled rising edges of cp,
// with optional shift-chain mode (channel 0 takes si, channel i takes old channel i-1).
module j_slatch_bank
  import j_latch_pkg::*;
#(
  parameter int               CHANNELS  = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SHIFT_EN  = 1'b1
) (
  input  logic          sys_clk,
  input  logic          reset,
  j_slatch_bank_if.slave bus
);

  logic                      cp_d;
  logic                      cp_rise;
  logic                      shift_mode;
  logic [CHANNELS*WIDTH-1:0] q_all;
  logic [CHANNELS-1:0]       chg_all;

  // cp sampling stage; reset parks cp_d high so a held-high cp is not an edge
  always_ff @(posedge sys_clk) begin
    if (reset) cp_d <= 1'b1;
    else       cp_d <= bus.cp;
  end

  assign cp_rise = bus.cp & ~cp_d;

  if (SHIFT_EN) begin : g_shift
    assign shift_mode = bus.shift;
  end else begin : g_no_shift
    assign shift_mode = 1'b0;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam int LO = chan_slice(i, WIDTH);

    latch_op_t        op;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] load_val;

    if (i == 0) begin : g_head
      assign shift_in = bus.si;
    end else begin : g_link
      assign shift_in = q_all[chan_slice(i - 1, WIDTH) +: WIDTH];
    end

    always_comb begin
      op = OP_HOLD;
      if (!bus.setl[i])                op = OP_SET;
      else if (cp_rise && shift_mode)  op = OP_SHIFT;
      else if (cp_rise && bus.en[i])   op = OP_LOAD;
    end

    assign load_val = shift_mode ? shift_in : bus.d[LO +: WIDTH];

    j_slatch_chan #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_chan (
      .sys_clk (sys_clk),
      .reset   (reset),
      .op      (op),
      .load_val(load_val),
      .q       (q_all[LO +: WIDTH]),
      .chg     (chg_all[i])
    );
  end

  assign bus.q   = q_all;
  assign bus.chg = chg_all;

endmodule

// File: tb/tb_j_slatch_bank.sv
// Bench for j_slatch_bank: directed vector table, random run against an array model,
// and a SHIFT_EN=0 variant.
module tb_j_slatch_bank;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  j_slatch_bank_if #(.CHANNELS(4), .WIDTH(8)) ia ();
  j_slatch_bank_if #(.CHANNELS(4), .WIDTH(8)) ib ();

  j_slatch_bank #(.CHANNELS(4), .WIDTH(8), .RESET_VAL(8'h5A), .SHIFT_EN(1'b1)) dut_a (
    .sys_clk(clk), .reset(rst_a), .bus(ia));

  j_slatch_bank #(.CHANNELS(4), .WIDTH(8), .RESET_VAL(8'h00), .SHIFT_EN(1'b0)) dut_b (
    .sys_clk(clk), .reset(rst_b), .bus(ib));

  typedef struct {
    logic        rst;
    logic        cp;
    logic [3:0]  en;
    logic [31:0] d;
    logic [3:0]  setl;
    logic        shift;
    logic [7:0]  si;
    logic [31:0] q;
    logic [3:0]  chg;
  } vec_t;

  vec_t tbl[24];

  // reference model state: one byte per channel plus the last sampled cp
  logic [7:0] mq[4];
  logic       mcp;

  function automatic vec_t mk(logic r, logic c, logic [3:0] e, logic [31:0] dd,
                              logic [3:0] sl, logic sh, logic [7:0] s,
                              logic [31:0] eq, logic [3:0] ech);
    vec_t v;
    v.rst = r; v.cp = c; v.en = e; v.d = dd; v.setl = sl;
    v.shift = sh; v.si = s; v.q = eq; v.chg = ech;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic c, input logic [3:0] e,
                            input logic [31:0] dd, input logic [3:0] sl, input logic sh,
                            input logic [7:0] s, output logic [31:0] eq,
                            output logic [3:0] ech);
    logic [7:0] nq[4];
    logic       rise;
    ech = 4'b0;
    if (r) begin
      for (int i = 0; i < 4; i++) nq[i] = 8'h5A;
      mcp = 1'b1;
    end else begin
      rise = c && !mcp;
      for (int i = 0; i < 4; i++) begin
        if (!sl[i])             nq[i] = 8'hFF;
        else if (rise && sh)    nq[i] = (i == 0) ? s : mq[i-1];
        else if (rise && e[i])  nq[i] = dd[8*i +: 8];
        else                    nq[i] = mq[i];
        ech[i] = (nq[i] != mq[i]);
      end
      mcp = c;
    end
    for (int i = 0; i < 4; i++) mq[i] = nq[i];
    eq = {mq[3], mq[2], mq[1], mq[0]};
  endtask

  task automatic drive_a(input logic r, input logic c, input logic [3:0] e,
                         input logic [31:0] dd, input logic [3:0] sl, input logic sh,
                         input logic [7:0] s, output logic [31:0] eq,
                         output logic [3:0] ech);
    rst_a = r; ia.cp = c; ia.en = e; ia.d = dd; ia.setl = sl; ia.shift = sh; ia.si = s;
    model_step(r, c, e, dd, sl, sh, s, eq, ech);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic r, input logic c, input logic [3:0] e,
                         input logic [31:0] dd, input logic sh, input logic [7:0] s);
    rst_b = r; ib.cp = c; ib.en = e; ib.d = dd; ib.setl = 4'hF; ib.shift = sh; ib.si = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] eq;
    logic [3:0]  ech;

    rst_b = 1'b1; ib.cp = 1'b1; ib.en = '0; ib.d = '0; ib.setl = 4'hF;
    ib.shift = 1'b0; ib.si = '0;

    //            rst cp en     d             setl   sh  si     q             chg
    tbl[0]  = mk(1, 1, 4'h0, 32'h00000000, 4'hF, 0, 8'h00, 32'h5A5A5A5A, 4'h0);
    tbl[1]  = mk(1, 1, 4'h0, 32'h00000000, 4'hF, 0, 8'h00, 32'h5A5A5A5A, 4'h0);
    tbl[2]  = mk(0, 1, 4'hF, 32'hFFFFFFFF, 4'hF, 0, 8'h00, 32'h5A5A5A5A, 4'h0);
    tbl[3]  = mk(0, 0, 4'h5, 32'h11223344, 4'hF, 0, 8'h00, 32'h5A5A5A5A, 4'h0);
    tbl[4]  = mk(0, 1, 4'h5, 32'h11223344, 4'hF, 0, 8'h00, 32'h5A225A44, 4'h5);
    tbl[5]  = mk(0, 1, 4'h5, 32'h11223344, 4'hF, 0, 8'h00, 32'h5A225A44, 4'h0);
    tbl[6]  = mk(0, 0, 4'hF, 32'h00000000, 4'hF, 0, 8'h00, 32'h5A225A44, 4'h0);
    tbl[7]  = mk(0, 1, 4'hF, 32'h00000000, 4'hF, 0, 8'h00, 32'h00000000, 4'hF);
    tbl[8]  = mk(0, 0, 4'h0, 32'h00000000, 4'hF, 1, 8'hC3, 32'h00000000, 4'h0);
    tbl[9]  = mk(0, 1, 4'h0, 32'h00000000, 4'hF, 1, 8'hC3, 32'h000000C3, 4'h1);
    tbl[10] = mk(0, 0, 4'h0, 32'h00000000, 4'hF, 1, 8'hC3, 32'h000000C3, 4'h0);
    tbl[11] = mk(0, 1, 4'hF, 32'hFFFFFFFF, 4'hF, 1, 8'hC3, 32'h0000C3C3, 4'h2);
    tbl[12] = mk(0, 0, 4'h0, 32'h00000000, 4'hF, 0, 8'h00, 32'h0000C3C3, 4'h0);
    tbl[13] = mk(0, 1, 4'hF, 32'h00000000, 4'hD, 0, 8'h00, 32'h0000FF00, 4'h3);
    tbl[14] = mk(0, 0, 4'hF, 32'h00000000, 4'hD, 0, 8'h00, 32'h0000FF00, 4'h0);
    tbl[15] = mk(0, 0, 4'hF, 32'h00000000, 4'hF, 0, 8'h00, 32'h0000FF00, 4'h0);
    tbl[16] = mk(0, 0, 4'hF, 32'h00000000, 4'hF, 0, 8'h00, 32'h0000FF00, 4'h0);
    tbl[17] = mk(0, 1, 4'hF, 32'h00000000, 4'hE, 1, 8'h12, 32'h00FF00FF, 4'h7);
    tbl[18] = mk(0, 0, 4'h0, 32'h00000000, 4'hF, 0, 8'h00, 32'h00FF00FF, 4'h0);
    tbl[19] = mk(1, 1, 4'hF, 32'hFFFFFFFF, 4'hF, 0, 8'h00, 32'h5A5A5A5A, 4'h0);
    tbl[20] = mk(0, 1, 4'hF, 32'hFFFFFFFF, 4'hF, 0, 8'h00, 32'h5A5A5A5A, 4'h0);
    tbl[21] = mk(0, 0, 4'hF, 32'h01020304, 4'hF, 0, 8'h00, 32'h5A5A5A5A, 4'h0);
    tbl[22] = mk(0, 1, 4'hF, 32'h01020304, 4'hF, 0, 8'h00, 32'h01020304, 4'hF);
    tbl[23] = mk(0, 0, 4'h0, 32'h00000000, 4'hF, 0, 8'h00, 32'h01020304, 4'h0);

    for (int k = 0; k < 24; k++) begin
      drive_a(tbl[k].rst, tbl[k].cp, tbl[k].en, tbl[k].d, tbl[k].setl,
              tbl[k].shift, tbl[k].si, eq, ech);
      chk($sformatf("vec%0d_q", k), ia.q, tbl[k].q);
      chk($sformatf("vec%0d_chg", k), {28'b0, ia.chg}, {28'b0, tbl[k].chg});
    end

    for (int n = 0; n < 400; n++) begin
      logic       r, c, sh;
      logic [3:0] e, sl;
      logic [31:0] dd;
      logic [7:0] s;
      r  = ($urandom_range(0, 49) == 0);
      c  = 1'($urandom_range(0, 1));
      e  = 4'($urandom);
      dd = $urandom;
      sl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      sh = 1'($urandom_range(0, 1));
      s  = 8'($urandom);
      drive_a(r, c, e, dd, sl, sh, s, eq, ech);
      chk($sformatf("rnd%0d_q", n), ia.q, eq);
      chk($sformatf("rnd%0d_chg", n), {28'b0, ia.chg}, {28'b0, ech});
    end

    // SHIFT_EN=0 variant: shift and si have no effect
    drive_b(1, 1, 4'h0, 32'h0, 0, 8'h00);
    chk("b_reset_q", ib.q, 32'h00000000);
    chk("b_reset_chg", {28'b0, ib.chg}, 32'h0);
    drive_b(0, 0, 4'hF, 32'hA5A5A5A5, 1, 8'h3C);
    chk("b_idle_q", ib.q, 32'h00000000);
    drive_b(0, 1, 4'hF, 32'hA5A5A5A5, 1, 8'h3C);
    chk("b_load_q", ib.q, 32'hA5A5A5A5);
    chk("b_load_chg", {28'b0, ib.chg}, 32'hF);
    drive_b(0, 0, 4'h0, 32'h0, 1, 8'h3C);
    chk("b_hold_chg", {28'b0, ib.chg}, 32'h0);
    drive_b(0, 1, 4'h5, 32'h0, 1, 8'h3C);
    chk("b_part_q", ib.q, 32'hA500A500);
    chk("b_part_chg", {28'b0, ib.chg}, 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
